// File: rtl/uart_pkg.sv
// uart_pkg: receiver/transmitter shared definitions (frame geometry, FSM state encodings, sampling helper).
package uart_pkg;

    localparam int UART_DATA_BITS       = 8;
    localparam int UART_IDLE_FRAME_BITS = 11;

    typedef enum logic [2:0] {
        POST_RESET = 3'd0,
        IDLE       = 3'd1,
        START      = 3'd2,
        DATA       = 3'd3,
        STOP       = 3'd4,
        WAIT_IDLE  = 3'd5
    } uart_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: down-counting bit-period timer; strobe_o marks the terminal count of a half or full period.
// The divider is captured on latch_i; a load in the same cycle already uses the freshly captured value.
module uart_bit_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] divider_i,
    input  logic             latch_i,
    input  logic             load_i,
    input  logic             half_i,
    input  logic             half_extra_i,
    output logic             strobe_o,
    output logic             running_o
);

    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] count_q;
    logic             run_q;
    logic [WIDTH-1:0] div_eff;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] half_wait;
    logic [WIDTH-1:0] load_value;

    always_comb begin
        div_eff   = (divider_i == '0) ? WIDTH'(1) : divider_i;
        period    = latch_i ? div_eff : div_q;
        half_wait = period >> 1;
        if (half_wait == '0) begin
            half_wait = WIDTH'(1);
        end
        // half_extra_i delays the half-period strobe by one clock so a sample window can straddle the midpoint
        half_wait  = half_wait + WIDTH'(half_extra_i);
        load_value = half_i ? (half_wait - WIDTH'(1)) : (period - WIDTH'(1));
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            div_q   <= WIDTH'(1);
            count_q <= '0;
            run_q   <= 1'b0;
        end else begin
            if (latch_i) begin
                div_q <= div_eff;
            end
            if (load_i) begin
                count_q <= load_value;
                run_q   <= 1'b1;
            end else if (run_q) begin
                if (count_q == '0) begin
                    run_q <= 1'b0;
                end else begin
                    count_q <= count_q - WIDTH'(1);
                end
            end
        end
    end

    assign strobe_o  = run_q && (count_q == '0);
    assign running_o = run_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling, stop-bit check and a one-entry holding register.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 majority sampling around each sample point (div >= 3).
//
// state      | meaning
// POST_RESET | count 11 idle bit periods before trusting the line
// IDLE       | line idle, waiting for a falling edge
// START      | wait half a bit, confirm start bit
// DATA       | sample 8 data bits, LSB first
// STOP       | sample stop bit, accept or flag framing error
// WAIT_IDLE  | after a bad stop bit, wait one full bit period of idle line
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_DIVIDER_WIDTH = 16
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
    input  logic                           serial_i,
    input  logic                           read_i,
    output logic [7:0]                     data_o,
    output logic                           valid_o,
    output logic                           framing_error_o,
    output logic                           overrun_o,
    output logic                           busy_o
);

    localparam int         CDW       = CLOCK_DIVIDER_WIDTH;
    localparam logic [3:0] IDLE_LAST = 4'(UART_IDLE_FRAME_BITS - 1);
    localparam logic [2:0] BIT_LAST  = 3'(UART_DATA_BITS - 1);

    uart_state_e state_q;
    uart_state_e state_d;

    logic [1:0] sync_q;
    logic       rx;
    logic       sample_bit;
    logic       div_le_one;
    logic       half_extra;
    logic       strobe;
    logic       running;

    logic timer_latch;
    logic timer_load;
    logic timer_half;
    logic idle_clr;
    logic idle_inc;
    logic idx_clr;
    logic shift_en;
    logic stop_ok;
    logic stop_fail;
    logic busy_state;

    logic [3:0] idle_cnt_q;
    logic [2:0] bit_idx_q;
    logic [7:0] shift_q;
    logic [7:0] data_q;
    logic       valid_q;
    logic       fe_q;
    logic       overrun_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], serial_i};
        end
    end

    assign rx         = sync_q[1];
    // with a one-clock bit there is no half-bit to wait: the IDLE detection is the start sample
    assign div_le_one = (clock_divider_i <= CDW'(1));

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic rx_d1_q;
    logic rx_d2_q;
    logic vote_ok_q;

    assign half_extra = (clock_divider_i >= CDW'(3));

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rx_d1_q   <= 1'b1;
            rx_d2_q   <= 1'b1;
            vote_ok_q <= 1'b0;
        end else begin
            rx_d1_q <= rx;
            rx_d2_q <= rx_d1_q;
            if (timer_latch) begin
                vote_ok_q <= half_extra;
            end
        end
    end

    // strobe lands one clock after the nominal point, so rx_d1_q is the centre of the window
    assign sample_bit = vote_ok_q ? majority3(rx_d2_q, rx_d1_q, rx) : rx;
`else
    assign half_extra = 1'b0;
    assign sample_bit = rx;
`endif

    uart_bit_timer #(
        .WIDTH(CDW)
    ) u_bit_timer (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .divider_i   (clock_divider_i),
        .latch_i     (timer_latch),
        .load_i      (timer_load),
        .half_i      (timer_half),
        .half_extra_i(half_extra),
        .strobe_o    (strobe),
        .running_o   (running)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= POST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            POST_RESET: if (rx && strobe && idle_cnt_q == IDLE_LAST) state_d = IDLE;
            IDLE:       if (!rx) state_d = div_le_one ? DATA : START;
            START:      if (strobe) state_d = sample_bit ? IDLE : DATA;
            DATA:       if (strobe && bit_idx_q == BIT_LAST) state_d = STOP;
            STOP:       if (strobe) state_d = sample_bit ? IDLE : WAIT_IDLE;
            WAIT_IDLE:  if (rx && strobe) state_d = IDLE;
            default:    state_d = POST_RESET;
        endcase
    end

    always_comb begin
        timer_latch = 1'b0;
        timer_load  = 1'b0;
        timer_half  = 1'b0;
        idle_clr    = 1'b0;
        idle_inc    = 1'b0;
        idx_clr     = 1'b0;
        shift_en    = 1'b0;
        stop_ok     = 1'b0;
        stop_fail   = 1'b0;
        busy_state  = 1'b1;
        case (state_q)
            POST_RESET: begin
                timer_latch = 1'b1;
                if (!rx || !running) begin
                    timer_load = 1'b1;
                    idle_clr   = 1'b1;
                end else if (strobe && idle_cnt_q != IDLE_LAST) begin
                    idle_inc   = 1'b1;
                    timer_load = 1'b1;
                end
            end
            IDLE: begin
                busy_state  = 1'b0;
                timer_latch = 1'b1;
                if (!rx) begin
                    timer_load = 1'b1;
                    timer_half = !div_le_one;
                    idx_clr    = 1'b1;
                end
            end
            START: begin
                if (strobe && !sample_bit) timer_load = 1'b1;
            end
            DATA: begin
                if (strobe) begin
                    shift_en   = 1'b1;
                    timer_load = 1'b1;
                end
            end
            STOP: begin
                if (strobe) begin
                    if (sample_bit) begin
                        stop_ok = 1'b1;
                    end else begin
                        stop_fail  = 1'b1;
                        timer_load = 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                if (!rx) timer_load = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            idle_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
        end else begin
            if (idle_clr) begin
                idle_cnt_q <= '0;
            end else if (idle_inc) begin
                idle_cnt_q <= idle_cnt_q + 4'd1;
            end
            if (idx_clr) begin
                bit_idx_q <= '0;
            end else if (shift_en) begin
                bit_idx_q <= bit_idx_q + 3'd1;
            end
            if (shift_en) begin
                shift_q <= {sample_bit, shift_q[7:1]};
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            fe_q <= stop_fail;
            if (stop_ok && (!valid_q || read_i)) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
                if (read_i && valid_q) overrun_q <= 1'b0;
            end else if (stop_ok) begin
                overrun_q <= 1'b1;
            end else if (read_i && valid_q) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end
        end
    end

    assign data_o          = data_q;
    assign valid_o         = valid_q;
    assign framing_error_o = fe_q;
    assign overrun_o       = overrun_q;
    assign busy_o          = reset_i | busy_state;

endmodule
